// File: rtl/afc.sv
// AFC controller: 7-bit successive-approximation search of the VCO cap band
// against an external counter, followed by an optional VCO amplitude trim.
module afc (
  input  logic        clk,
  input  logic        rstn,
  input  logic        afc_cg_auto,
  input  logic        afc_en,
  input  logic        trx,
  input  logic [15:0] divr,
  input  logic        rg_forceband_en,
  input  logic [6:0]  rg_vco_capband,
  input  logic [1:0]  rg_afc_vcostable_time,
  input  logic [6:0]  rg_afc_cnt_time,
  input  logic [13:0] a2d_afc_ncntr,
  input  logic        rg_aac_bypass,
  input  logic [1:0]  rg_aac_stable_time,
  input  logic [1:0]  rg_aac_cbandrange,
  input  logic [3:0]  rg_ini_ibsel_rx,
  input  logic [3:0]  rg_ini_ibsel_tx,
  input  logic        a2d_aac_pkd_state,
  output logic        afc_openloop_en,
  output logic [6:0]  afc_vco_capband,
  output logic        afc_cntr_rstn,
  output logic        afc_cntr_en,
  output logic        afc_cntr_datasyn,
  output logic [3:0]  afc_ibvco,
  output logic [13:0] afc_minerr,
  output logic        afc_finish
);

  typedef enum logic [3:0] {
    IDLE     = 4'd0,
    INIT     = 4'd1,
    VCO_WAIT = 4'd2,
    CNT_RST  = 4'd3,
    CNT      = 4'd4,
    SYNC     = 4'd5,
    CMP      = 4'd6,
    AAC      = 4'd7,
    DONE     = 4'd8
  } state_t;

  state_t      st_curr;
  state_t      st_next;
  logic [13:0] ndec_reg;

  logic        r_en_d;
  logic [6:0]  r_capband;
  logic [3:0]  r_ibvco;
  logic [13:0] r_minerr;
  logic        r_openloop;
  logic        r_cntr_rstn;
  logic        r_cntr_en;
  logic        r_datasyn;
  logic        r_finish;
  logic [6:0]  r_trial;
  logic [6:0]  r_result;
  logic [6:0]  r_best;
  logic [2:0]  r_bit;
  logic [6:0]  r_cnt;
  logic [3:0]  r_steps;

  logic        w_rise;
  logic        w_upd;
  logic [7:0]  w_np1;
  logic [21:0] w_mult;
  logic [13:0] w_ndec;
  logic [6:0]  w_vco_lim;
  logic [6:0]  w_aac_lim;
  logic [3:0]  w_aac_max;
  logic [13:0] w_err;
  logic        w_ge;
  logic        w_better;
  logic [6:0]  w_kept;
  logic [6:0]  w_next_trial;
  logic        w_act;

  logic [13:0] w_ndec_nx;
  logic [6:0]  w_capband_nx;
  logic [3:0]  w_ibvco_nx;
  logic [13:0] w_minerr_nx;
  logic [6:0]  w_trial_nx;
  logic [6:0]  w_result_nx;
  logic [6:0]  w_best_nx;
  logic [2:0]  w_bit_nx;
  logic [6:0]  w_cnt_nx;
  logic [3:0]  w_steps_nx;
  logic        w_openloop_nx;
  logic        w_cntr_rstn_nx;
  logic        w_cntr_en_nx;
  logic        w_datasyn_nx;
  logic        w_finish_nx;

  assign w_rise = afc_en & ~r_en_d;
  // Idle cycles without a start edge change nothing, so gating them is invisible.
  assign w_upd  = ~afc_cg_auto | (st_curr != IDLE) | w_rise;

  assign w_np1  = {1'b0, rg_afc_cnt_time} + 8'd1;
  assign w_mult = {6'd0, divr} * {14'd0, w_np1};
  assign w_ndec = 14'((w_mult + 22'd128) >> 8);

  assign w_ge         = (a2d_afc_ncntr >= ndec_reg);
  assign w_err        = w_ge ? (a2d_afc_ncntr - ndec_reg) : (ndec_reg - a2d_afc_ncntr);
  assign w_better     = (w_err < r_minerr);
  assign w_kept       = w_ge ? r_trial : (r_trial & ~(7'd1 << r_bit));
  assign w_next_trial = w_kept | (7'd1 << (r_bit - 3'd1));

  // Settle times are the index of the last wait cycle; AAC step limit per range code.
  always_comb begin
    case (rg_afc_vcostable_time)
      2'd0:    w_vco_lim = 7'd7;
      2'd1:    w_vco_lim = 7'd15;
      2'd2:    w_vco_lim = 7'd31;
      default: w_vco_lim = 7'd63;
    endcase
    case (rg_aac_stable_time)
      2'd0:    w_aac_lim = 7'd7;
      2'd1:    w_aac_lim = 7'd15;
      2'd2:    w_aac_lim = 7'd31;
      default: w_aac_lim = 7'd63;
    endcase
    case (rg_aac_cbandrange)
      2'd0:    w_aac_max = 4'd2;
      2'd1:    w_aac_max = 4'd4;
      2'd2:    w_aac_max = 4'd8;
      default: w_aac_max = 4'd15;
    endcase
  end

  // Next-state and next-register values; outputs are derived from the next state.
  always_comb begin
    st_next      = st_curr;
    w_ndec_nx    = ndec_reg;
    w_capband_nx = r_capband;
    w_ibvco_nx   = r_ibvco;
    w_minerr_nx  = r_minerr;
    w_trial_nx   = r_trial;
    w_result_nx  = r_result;
    w_best_nx    = r_best;
    w_bit_nx     = r_bit;
    w_cnt_nx     = r_cnt + 7'd1;
    w_steps_nx   = r_steps;
    case (st_curr)
      IDLE, DONE: begin
        w_cnt_nx = 7'd0;
        if (w_rise) st_next = INIT;
        else        st_next = st_curr;
      end
      INIT: begin
        w_ndec_nx   = w_ndec;
        w_minerr_nx = 14'h3FFF;
        w_ibvco_nx  = trx ? rg_ini_ibsel_tx : rg_ini_ibsel_rx;
        w_steps_nx  = 4'd0;
        w_cnt_nx    = 7'd0;
        if (rg_forceband_en) begin
          w_capband_nx = rg_vco_capband;
          st_next      = rg_aac_bypass ? DONE : AAC;
        end else begin
          w_result_nx  = 7'd0;
          w_bit_nx     = 3'd6;
          w_trial_nx   = 7'd64;
          w_best_nx    = 7'd64;
          w_capband_nx = 7'd64;
          st_next      = VCO_WAIT;
        end
      end
      VCO_WAIT: begin
        if (r_cnt == w_vco_lim) begin
          w_cnt_nx = 7'd0;
          st_next  = CNT_RST;
        end else begin
          st_next  = VCO_WAIT;
        end
      end
      CNT_RST: begin
        w_cnt_nx = 7'd0;
        st_next  = CNT;
      end
      CNT: begin
        if (r_cnt == rg_afc_cnt_time) begin
          w_cnt_nx = 7'd0;
          st_next  = SYNC;
        end else begin
          st_next  = CNT;
        end
      end
      SYNC: begin
        w_cnt_nx = 7'd0;
        st_next  = CMP;
      end
      CMP: begin
        w_cnt_nx    = 7'd0;
        w_result_nx = w_kept;
        if (w_better) begin
          w_minerr_nx = w_err;
          w_best_nx   = r_trial;
        end else begin
          w_minerr_nx = r_minerr;
          w_best_nx   = r_best;
        end
        if (r_bit != 3'd0) begin
          w_trial_nx   = w_next_trial;
          w_capband_nx = w_next_trial;
          w_bit_nx     = r_bit - 3'd1;
          st_next      = VCO_WAIT;
        end else begin
          w_capband_nx = w_better ? r_trial : r_best;
          st_next      = rg_aac_bypass ? DONE : AAC;
        end
      end
      AAC: begin
        if (r_cnt == w_aac_lim) begin
          w_cnt_nx = 7'd0;
          if (a2d_aac_pkd_state && (r_ibvco != 4'd0) && (r_steps < w_aac_max)) begin
            w_ibvco_nx = r_ibvco - 4'd1;
            w_steps_nx = r_steps + 4'd1;
            st_next    = AAC;
          end else begin
            st_next    = DONE;
          end
        end else begin
          st_next = AAC;
        end
      end
      default: begin
        w_cnt_nx = 7'd0;
        st_next  = IDLE;
      end
    endcase

    w_act          = (st_next inside {INIT, VCO_WAIT, CNT_RST, CNT, SYNC, CMP}) && !rg_forceband_en;
    w_openloop_nx  = w_act;
    w_cntr_rstn_nx = w_act && (st_next != CNT_RST);
    w_cntr_en_nx   = (st_next == CNT);
    w_datasyn_nx   = (st_next == SYNC);
    w_finish_nx    = (st_next == DONE);
  end

  // Start-edge detector; resets high so a level held through reset is not a start.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) r_en_d <= 1'b1;
    else      r_en_d <= afc_en;
  end

  // State, datapath and registered outputs.
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      st_curr     <= IDLE;
      ndec_reg    <= 14'd0;
      r_capband   <= 7'd64;
      r_ibvco     <= 4'd0;
      r_minerr    <= 14'h3FFF;
      r_trial     <= 7'd64;
      r_result    <= 7'd0;
      r_best      <= 7'd64;
      r_bit       <= 3'd6;
      r_cnt       <= 7'd0;
      r_steps     <= 4'd0;
      r_openloop  <= 1'b0;
      r_cntr_rstn <= 1'b0;
      r_cntr_en   <= 1'b0;
      r_datasyn   <= 1'b0;
      r_finish    <= 1'b0;
    end else if (w_upd) begin
      st_curr     <= st_next;
      ndec_reg    <= w_ndec_nx;
      r_capband   <= w_capband_nx;
      r_ibvco     <= w_ibvco_nx;
      r_minerr    <= w_minerr_nx;
      r_trial     <= w_trial_nx;
      r_result    <= w_result_nx;
      r_best      <= w_best_nx;
      r_bit       <= w_bit_nx;
      r_cnt       <= w_cnt_nx;
      r_steps     <= w_steps_nx;
      r_openloop  <= w_openloop_nx;
      r_cntr_rstn <= w_cntr_rstn_nx;
      r_cntr_en   <= w_cntr_en_nx;
      r_datasyn   <= w_datasyn_nx;
      r_finish    <= w_finish_nx;
    end
  end

  assign afc_openloop_en  = r_openloop;
  assign afc_vco_capband  = r_capband;
  assign afc_cntr_rstn    = r_cntr_rstn;
  assign afc_cntr_en      = r_cntr_en;
  assign afc_cntr_datasyn = r_datasyn;
  assign afc_ibvco        = r_ibvco;
  assign afc_minerr       = r_minerr;
  assign afc_finish       = r_finish;

endmodule

// File: tb/tb_afc.sv
// Scoreboard bench for afc: a reference model predicts each run's results,
// a monitor pops the prediction when finish rises and compares.
module tb_afc;

  logic        clk = 1'b0;
  logic        rstn;
  logic        afc_cg_auto;
  logic        afc_en;
  logic        trx;
  logic [15:0] divr;
  logic        rg_forceband_en;
  logic [6:0]  rg_vco_capband;
  logic [1:0]  rg_afc_vcostable_time;
  logic [6:0]  rg_afc_cnt_time;
  logic [13:0] a2d_afc_ncntr;
  logic        rg_aac_bypass;
  logic [1:0]  rg_aac_stable_time;
  logic [1:0]  rg_aac_cbandrange;
  logic [3:0]  rg_ini_ibsel_rx;
  logic [3:0]  rg_ini_ibsel_tx;
  logic        a2d_aac_pkd_state;
  logic        afc_openloop_en;
  logic [6:0]  afc_vco_capband;
  logic        afc_cntr_rstn;
  logic        afc_cntr_en;
  logic        afc_cntr_datasyn;
  logic [3:0]  afc_ibvco;
  logic [13:0] afc_minerr;
  logic        afc_finish;

  always #5 clk = ~clk;

  afc dut (
    .clk(clk), .rstn(rstn), .afc_cg_auto(afc_cg_auto), .afc_en(afc_en), .trx(trx),
    .divr(divr), .rg_forceband_en(rg_forceband_en), .rg_vco_capband(rg_vco_capband),
    .rg_afc_vcostable_time(rg_afc_vcostable_time), .rg_afc_cnt_time(rg_afc_cnt_time),
    .a2d_afc_ncntr(a2d_afc_ncntr), .rg_aac_bypass(rg_aac_bypass),
    .rg_aac_stable_time(rg_aac_stable_time), .rg_aac_cbandrange(rg_aac_cbandrange),
    .rg_ini_ibsel_rx(rg_ini_ibsel_rx), .rg_ini_ibsel_tx(rg_ini_ibsel_tx),
    .a2d_aac_pkd_state(a2d_aac_pkd_state), .afc_openloop_en(afc_openloop_en),
    .afc_vco_capband(afc_vco_capband), .afc_cntr_rstn(afc_cntr_rstn),
    .afc_cntr_en(afc_cntr_en), .afc_cntr_datasyn(afc_cntr_datasyn),
    .afc_ibvco(afc_ibvco), .afc_minerr(afc_minerr), .afc_finish(afc_finish)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Analog environment: counter falls linearly with cap band, detector trips above a bias threshold.
  int cfg_base  = 1600;
  int cfg_slope = 10;
  int cfg_thr   = 16;

  always_comb begin
    a2d_afc_ncntr     = 14'(cfg_base - cfg_slope * int'(afc_vco_capband));
    a2d_aac_pkd_state = (int'(afc_ibvco) > cfg_thr);
  end

  typedef struct packed {
    logic [6:0]      band;
    logic [13:0]     minerr;
    logic [3:0]      ibvco;
    logic [13:0]     ndec;
    logic [3:0]      nwin;
    logic [7:0]      wlen;
    logic [6:0][6:0] trials;
    logic            ol;
  } exp_t;

  exp_t q[$];

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int meas_of(input int band);
    return (cfg_base - cfg_slope * band) % 16384;
  endfunction

  function automatic exp_t model();
    exp_t e;
    int   m, nd, res, tr, meas, err, mn, best, ib, steps, mx;
    e  = '0;
    m  = (int'(divr) * (int'(rg_afc_cnt_time) + 1)) % (1 << 22);
    nd = ((m + 128) / 256) % 16384;
    e.ndec = 14'(nd);
    e.ol   = !rg_forceband_en;
    mn     = 16383;
    if (rg_forceband_en) begin
      e.band = rg_vco_capband;
      e.nwin = 4'd0;
    end else begin
      res  = 0;
      best = 64;
      for (int k = 6; k >= 0; k--) begin
        tr = res + (1 << k);
        e.trials[6 - k] = 7'(tr);
        meas = meas_of(tr);
        err  = (meas >= nd) ? meas - nd : nd - meas;
        if (err < mn) begin mn = err; best = tr; end
        if (meas >= nd) res = tr;
      end
      e.band = 7'(best);
      e.nwin = 4'd7;
      e.wlen = 8'(int'(rg_afc_cnt_time) + 1);
    end
    e.minerr = 14'(mn);
    ib = trx ? int'(rg_ini_ibsel_tx) : int'(rg_ini_ibsel_rx);
    mx = (rg_aac_cbandrange == 2'd0) ? 2 : (rg_aac_cbandrange == 2'd1) ? 4 :
         (rg_aac_cbandrange == 2'd2) ? 8 : 15;
    steps = 0;
    if (!rg_aac_bypass) begin
      while (ib > 0 && steps < mx && ib > cfg_thr) begin
        ib--;
        steps++;
      end
    end
    e.ibvco = 4'(ib);
    return e;
  endfunction

  // Monitor: collects counter windows and trial bands, scores each finished run.
  initial begin
    bit   prev_fin, prev_cen, obs_ol;
    int   wl;
    int   obs_trials[$];
    int   obs_wins[$];
    exp_t e;
    prev_fin = 1'b0; prev_cen = 1'b0; obs_ol = 1'b0; wl = 0;
    forever begin
      @(negedge clk);
      if (rstn) begin
        prev_fin = 1'b0; prev_cen = 1'b0; obs_ol = 1'b0; wl = 0;
        obs_trials.delete(); obs_wins.delete();
      end else begin
        if (int'(dut.st_curr) == 1) begin
          check("finish_clear_on_start", int'(afc_finish), 0);
          obs_ol = 1'b0; obs_trials.delete(); obs_wins.delete();
        end
        if (afc_openloop_en) obs_ol = 1'b1;
        if (afc_cntr_en) begin
          if (!prev_cen) begin
            obs_trials.push_back(int'(afc_vco_capband));
            wl = 0;
          end
          wl++;
        end else if (prev_cen) begin
          obs_wins.push_back(wl);
        end
        if (afc_finish && !prev_fin) begin
          if (q.size() == 0) begin
            check("unexpected_finish", 1, 0);
          end else begin
            e = q.pop_front();
            check("capband", int'(afc_vco_capband), int'(e.band));
            check("minerr", int'(afc_minerr), int'(e.minerr));
            check("ibvco", int'(afc_ibvco), int'(e.ibvco));
            check("ndec_reg", int'(dut.ndec_reg), int'(e.ndec));
            check("st_done", int'(dut.st_curr), 8);
            check("openloop_seen", int'(obs_ol), int'(e.ol));
            check("num_windows", obs_wins.size(), int'(e.nwin));
            foreach (obs_wins[i]) check("window_len", obs_wins[i], int'(e.wlen));
            if (obs_trials.size() == int'(e.nwin)) begin
              foreach (obs_trials[i]) check("trial_band", obs_trials[i], int'(e.trials[i]));
            end
          end
        end
        prev_cen = afc_cntr_en;
        prev_fin = afc_finish;
      end
    end
  end

  task automatic run_cal(input bit push);
    int cyc;
    afc_en = 1'b0;
    @(posedge clk); #1;
    if (push) q.push_back(model());
    afc_en = 1'b1;
    @(posedge clk); #1;
    cyc = 0;
    while (!afc_finish && cyc < 6000) begin
      @(posedge clk); #1;
      cyc++;
    end
    if (!afc_finish) begin
      check("finish_timeout", 0, 1);
      q.delete();
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic set_defaults();
    afc_cg_auto = 1'b0; trx = 1'b0; divr = 16'h1234;
    rg_forceband_en = 1'b0; rg_vco_capband = 7'd0;
    rg_afc_vcostable_time = 2'd0; rg_afc_cnt_time = 7'd18;
    rg_aac_bypass = 1'b1; rg_aac_stable_time = 2'd0; rg_aac_cbandrange = 2'd1;
    rg_ini_ibsel_rx = 4'd9; rg_ini_ibsel_tx = 4'd3;
    cfg_base = 1600; cfg_slope = 10; cfg_thr = 16;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_st"}, int'(dut.st_curr), 0);
    check({tag, "_ndec"}, int'(dut.ndec_reg), 0);
    check({tag, "_capband"}, int'(afc_vco_capband), 64);
    check({tag, "_ibvco"}, int'(afc_ibvco), 0);
    check({tag, "_minerr"}, int'(afc_minerr), 16383);
    check({tag, "_openloop"}, int'(afc_openloop_en), 0);
    check({tag, "_cntr_rstn"}, int'(afc_cntr_rstn), 0);
    check({tag, "_cntr_en"}, int'(afc_cntr_en), 0);
    check({tag, "_datasyn"}, int'(afc_cntr_datasyn), 0);
    check({tag, "_finish"}, int'(afc_finish), 0);
  endtask

  initial begin
    int  cyc;
    bit  fin_seen;
    rstn = 1'b1;
    afc_en = 1'b0;
    set_defaults();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rstn = 1'b0;

    // Nominal search: expected trials 64..125, best band 125 with error 4.
    run_cal(1'b1);
    check("plan_ndec_n18", int'(dut.ndec_reg), 'h15A);
    check("plan_band", int'(afc_vco_capband), 125);
    check("plan_minerr", int'(afc_minerr), 4);
    check("plan_finish", int'(afc_finish), 1);

    rg_afc_cnt_time = 7'd63;
    run_cal(1'b1);
    check("plan_ndec_n63", int'(dut.ndec_reg), 'h48D);

    rg_afc_cnt_time = 7'd18;
    rg_forceband_en = 1'b1;
    rg_vco_capband  = 7'd37;
    run_cal(1'b1);
    check("plan_force_band", int'(afc_vco_capband), 37);

    rg_vco_capband = 7'd50;
    rg_aac_bypass  = 1'b0;
    cfg_thr        = -1;
    run_cal(1'b1);
    check("plan_aac_pkd1", int'(afc_ibvco), 5);
    cfg_thr = 16;
    afc_cg_auto = 1'b1;
    run_cal(1'b1);
    check("plan_aac_pkd0", int'(afc_ibvco), 9);

    // Reset in the middle of a count window, start level held high afterwards.
    set_defaults();
    afc_en = 1'b0;
    @(posedge clk); #1;
    afc_en = 1'b1;
    cyc = 0;
    while (int'(dut.st_curr) != 4 && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("reach_cnt", int'(dut.st_curr), 4);
    rstn = 1'b1;
    #1;
    check_reset_outputs("midreset");
    @(posedge clk); #1;
    rstn = 1'b0;
    fin_seen = 1'b0;
    repeat (300) begin
      @(posedge clk); #1;
      if (afc_finish) fin_seen = 1'b1;
    end
    check("no_finish_after_reset", int'(fin_seen), 0);
    check("idle_after_reset", int'(dut.st_curr), 0);

    // Randomized back-to-back runs.
    for (int r = 0; r < 20; r++) begin
      afc_cg_auto           = 1'($urandom_range(0, 1));
      trx                   = 1'($urandom_range(0, 1));
      divr                  = 16'($urandom_range(0, 65535));
      rg_forceband_en       = ($urandom_range(0, 4) == 0);
      rg_vco_capband        = 7'($urandom_range(0, 127));
      rg_afc_vcostable_time = 2'($urandom_range(0, 3));
      rg_afc_cnt_time       = 7'($urandom_range(0, 40));
      rg_aac_bypass         = 1'($urandom_range(0, 1));
      rg_aac_stable_time    = 2'($urandom_range(0, 3));
      rg_aac_cbandrange     = 2'($urandom_range(0, 3));
      rg_ini_ibsel_rx       = 4'($urandom_range(0, 15));
      rg_ini_ibsel_tx       = 4'($urandom_range(0, 15));
      cfg_slope             = int'($urandom_range(1, 60));
      cfg_base              = cfg_slope * 127 + int'($urandom_range(0, 8000));
      cfg_thr               = int'($urandom_range(0, 17)) - 1;
      run_cal(1'b1);
    end

    check("scoreboard_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/afc.md
Name: afc

Overview:
- Automatic frequency calibration (AFC) controller for a PLL VCO.
- Computes an expected count `ndec` from `divr` and the count window.
- Runs a 7-bit successive-approximation search of the VCO cap band against an external frequency counter and keeps the minimum-error band.
- Then runs an optional amplitude calibration (AAC) that trims VCO bias current; sits between the register bank and the analog PLL/counter.

Parameters:
- None. All widths fixed.

Ports:
- clk  in  1  system clock
- rstn  in  1  reset; asynchronous, active-high (asserted = 1)
- afc_cg_auto  in  1  auto clock-gate enable; functionally transparent, outputs identical either value
- afc_en  in  1  calibration start; rising edge starts a run
- trx  in  1  0=RX, 1=TX; selects initial bias
- divr  in  16  fractional divider ratio, 8.8 format
- rg_forceband_en  in  1  skip AFC search, use rg_vco_capband
- rg_vco_capband  in  7  forced cap band
- rg_afc_vcostable_time  in  2  VCO settle: 0/1/2/3 = 8/16/32/64 cycles
- rg_afc_cnt_time  in  7  count window N; window = N+1 cycles
- a2d_afc_ncntr  in  14  counter result
- rg_aac_bypass  in  1  skip AAC
- rg_aac_stable_time  in  2  AAC settle: 8/16/32/64 cycles
- rg_aac_cbandrange  in  2  AAC max steps: 2/4/8/15
- rg_ini_ibsel_rx  in  4  initial ibvco, RX
- rg_ini_ibsel_tx  in  4  initial ibvco, TX
- a2d_aac_pkd_state  in  1  peak detector, 1 = amplitude above threshold
- afc_openloop_en  out  1  VCO open-loop during AFC phase
- afc_vco_capband  out  7  cap band
- afc_cntr_rstn  out  1  counter reset, active low
- afc_cntr_en  out  1  counter enable (count window)
- afc_cntr_datasyn  out  1  counter result latch strobe
- afc_ibvco  out  4  VCO bias select
- afc_minerr  out  14  minimum |ncntr-ndec| found
- afc_finish  out  1  calibration done (level)

Behaviour:
- State register `st_curr` (4 bit) encoding: IDLE=0, INIT=1, VCO_WAIT=2, CNT_RST=3, CNT=4, SYNC=5, CMP=6, AAC=7, DONE=8.
- Internal register `ndec_reg` [13:0]. Both names are probed by verification.
- Reset values: st_curr=IDLE, capband=64, ibvco=0, minerr=14'h3FFF, ndec_reg=0, openloop_en=0, cntr_rstn=0, cntr_en=0, datasyn=0, finish=0.
- afc_en rising edge, from IDLE or DONE → INIT. Edges while busy are ignored.
- INIT, 1 cycle:
  - mult[22:0] = divr*(N+1), truncated to 23 bits.
  - ndec_reg = mult[21:8] + mult[7], 14-bit wrap.
  - minerr=3FFF; ibvco = trx ? ini_tx : ini_rx.
  - forceband=1: capband=rg_vco_capband, go to AAC (or DONE if bypass).
  - Else: result=0, bit=6, trial=64, go to VCO_WAIT.
- VCO_WAIT: capband=trial; wait vcostable cycles → CNT_RST.
- CNT_RST: cntr_rstn=0 for 1 cycle (cntr_rstn=1 in all other AFC states) → CNT.
- CNT: cntr_en=1 for exactly N+1 cycles → SYNC.
- SYNC: datasyn=1 for 1 cycle → CMP. ncntr is sampled in CMP, the cycle after datasyn.
- CMP:
  - err=|ncntr-ndec_reg|.
  - If err<minerr (strict; ties keep earliest): minerr=err, best=trial.
  - Keep trial bit if ncntr>=ndec_reg (VCO fast → more cap), else clear it.
  - If bit>0: next trial = result|(1<<(bit-1)), back to VCO_WAIT.
  - Else: capband=best, go to AAC (or DONE if bypass).
  - Exactly 7 measurements per run.
- openloop_en=1 in states 1–6 when forceband=0; 0 otherwise.
- AAC loop:
  - Wait aac_stable cycles, then sample pkd_state.
  - If 1 and ibvco>0 and steps<max: ibvco-=1, repeat.
  - Else → DONE.
- DONE: finish=1. Sticky until next afc_en rising edge; capband, ibvco, minerr, ndec_reg held.
- Leaving DONE clears finish on the next cycle.
- Reset mid-operation: all registers return to reset values immediately; no finish pulse.
- afc_cg_auto has no functional effect.

Test Plan:
- divr=16'h1234, N=18 → ndec_reg=14'h015A at st_curr=8. Same with N=63 → 14'h048D.
- N=18, divr=16'h1234, ncntr(band)=1600-10*band, bypass=1:
  - trials 64,96,112,120,124,126,125;
  - afc_vco_capband=125, afc_minerr=4, finish=1;
  - 7 cntr_en windows of 19 cycles each.
- forceband=1, rg_vco_capband=37, bypass=1 → capband=37, no cntr_en activity, openloop_en=0, finish=1.
- trx=0, ini_rx=9, pkd=1 constant, cbandrange=1, bypass=0 → ibvco 9→5 (4 steps) then finish. With pkd=0 → ibvco stays 9.
- Two back-to-back runs: finish drops one cycle after second afc_en rise; second run's results are independent of the first.
- rstn asserted during CNT → all outputs at reset values; no finish until a new afc_en rise.
